// File: rtl/ram_1p_arbiter.sv
// rtl/ram_1p_arbiter.sv - two-host arbiter and address range checker in front of a single-port RAM
//
// Lets host A (instruction port) and host B (data port) share one 1-cycle RAM.
// At most one request is granted per cycle. The winning request goes to the RAM
// only if its address falls inside the RAM window. Each response is routed back
// to the host that issued it, and the other host sees all-zero response fields.
//
// Configuration macro: RAM_ARB_ROUND_ROBIN_EN
//   defined   : priority alternates after every grant (strict alternation under contention)
//   undefined : host B always wins under contention (fixed priority)
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   a_req_i / a_gnt_o             host A request, same-cycle grant
//   a_we_i, a_be_i                host A write enable, byte enables
//   a_addr_i, a_wdata_i           host A byte address, write data
//   a_rvalid_o, a_rdata_o, a_err_o host A response (one cycle after grant)
//   b_*                           host B, same set as host A
//   ram_req_o .. ram_wdata_o      request to the RAM, address is the offset from AddrBase
//   ram_rvalid_i, ram_rdata_i     RAM response
module ram_1p_arbiter #(
    parameter int unsigned Depth    = 128,
    parameter logic [31:0] AddrBase = 32'h0010_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        a_req_i,
    output logic        a_gnt_o,
    input  logic        a_we_i,
    input  logic [3:0]  a_be_i,
    input  logic [31:0] a_addr_i,
    input  logic [31:0] a_wdata_i,
    output logic        a_rvalid_o,
    output logic [31:0] a_rdata_o,
    output logic        a_err_o,

    input  logic        b_req_i,
    output logic        b_gnt_o,
    input  logic        b_we_i,
    input  logic [3:0]  b_be_i,
    input  logic [31:0] b_addr_i,
    input  logic [31:0] b_wdata_i,
    output logic        b_rvalid_o,
    output logic [31:0] b_rdata_o,
    output logic        b_err_o,

    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic        ram_rvalid_i,
    input  logic [31:0] ram_rdata_i
);

    typedef enum logic {
        HOST_A = 1'b0,
        HOST_B = 1'b1
    } host_e;

    localparam logic [31:0] WindowBytes = 32'(Depth * 4);

    host_e       prio_q;
    host_e       owner_q;
    logic        pending_q;
    logic        err_q;
    logic        we_q;

    logic        a_win;
    logic        b_win;
    logic        granted;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [31:0] offset;
    logic        in_range;
    logic        resp_valid;
    logic [31:0] resp_data;

    // Arbitration and request forwarding
    always_comb begin
        a_win     = a_req_i && (!b_req_i || (prio_q == HOST_A));
        b_win     = b_req_i && !a_win;
        granted   = a_win || b_win;

        sel_we    = b_win ? b_we_i    : a_we_i;
        sel_be    = b_win ? b_be_i    : a_be_i;
        sel_addr  = b_win ? b_addr_i  : a_addr_i;
        sel_wdata = b_win ? b_wdata_i : a_wdata_i;

        // Wrapping subtraction: addresses below the base wrap to huge offsets
        // and fail the compare, so one compare covers both window edges.
        offset    = sel_addr - AddrBase;
        in_range  = offset < WindowBytes;

        ram_req_o   = granted && in_range;
        ram_we_o    = ram_req_o ? sel_we    : 1'b0;
        ram_be_o    = ram_req_o ? sel_be    : 4'b0000;
        ram_addr_o  = ram_req_o ? offset    : 32'h0;
        ram_wdata_o = ram_req_o ? sel_wdata : 32'h0;

        a_gnt_o   = a_win;
        b_gnt_o   = b_win;
    end

    // One-deep response tracking; rejected requests still get an error response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= 1'b0;
            owner_q   <= HOST_A;
            err_q     <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            pending_q <= granted;
            if (granted) begin
                owner_q <= b_win ? HOST_B : HOST_A;
                err_q   <= !in_range;
                we_q    <= sel_we;
            end
        end
    end

`ifdef RAM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= HOST_B;
        end else if (a_win) begin
            prio_q <= HOST_B;
        end else if (b_win) begin
            prio_q <= HOST_A;
        end
    end
`else
    assign prio_q = HOST_B;
`endif

    // A stray RAM valid without an outstanding grant is dropped here.
    // Error responses never went to the RAM, so they do not wait for it.
    always_comb begin
        resp_valid = pending_q && (err_q || ram_rvalid_i);
        resp_data  = (resp_valid && !err_q && !we_q) ? ram_rdata_i : 32'h0;

        a_rvalid_o = resp_valid && (owner_q == HOST_A);
        a_err_o    = a_rvalid_o && err_q;
        a_rdata_o  = (owner_q == HOST_A) ? resp_data : 32'h0;

        b_rvalid_o = resp_valid && (owner_q == HOST_B);
        b_err_o    = b_rvalid_o && err_q;
        b_rdata_o  = (owner_q == HOST_B) ? resp_data : 32'h0;
    end

endmodule

// File: tb/tb_ram_1p_arbiter.sv
// tb/tb_ram_1p_arbiter.sv - self-checking bench for ram_1p_arbiter
module tb_ram_1p_arbiter;

    localparam logic [31:0] BASE  = 32'h0010_0000;
    localparam int          WORDS = 128;

    logic        clk;
    logic        rst_n;

    logic        a_req, a_gnt, a_we, a_rvalid, a_err;
    logic [3:0]  a_be;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_req, b_gnt, b_we, b_rvalid, b_err;
    logic [3:0]  b_be;
    logic [31:0] b_addr, b_wdata, b_rdata;

    logic        ram_req, ram_we, ram_rvalid;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    int checks = 0;
    int errors = 0;

    // RAM behaviour
    logic [31:0] seed;
    logic        ram_load;
    logic        force_rv;
    logic [31:0] mem [WORDS];
    logic        rv_q;
    logic [31:0] rd_q;

    // reference model state
    logic [31:0] ref_mem [WORDS];
    logic        m_pend;
    logic        m_owner_b;
    logic        m_err;
    logic [31:0] m_rdata;
    logic        m_prio_b;

    logic [1:0]  obs_gnt;
    logic [31:0] obs_b_rdata;

    ram_1p_arbiter dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .a_req_i      (a_req),
        .a_gnt_o      (a_gnt),
        .a_we_i       (a_we),
        .a_be_i       (a_be),
        .a_addr_i     (a_addr),
        .a_wdata_i    (a_wdata),
        .a_rvalid_o   (a_rvalid),
        .a_rdata_o    (a_rdata),
        .a_err_o      (a_err),
        .b_req_i      (b_req),
        .b_gnt_o      (b_gnt),
        .b_we_i       (b_we),
        .b_be_i       (b_be),
        .b_addr_i     (b_addr),
        .b_wdata_i    (b_wdata),
        .b_rvalid_o   (b_rvalid),
        .b_rdata_o    (b_rdata),
        .b_err_o      (b_err),
        .ram_req_o    (ram_req),
        .ram_we_o     (ram_we),
        .ram_be_o     (ram_be),
        .ram_addr_o   (ram_addr),
        .ram_wdata_o  (ram_wdata),
        .ram_rvalid_i (ram_rvalid),
        .ram_rdata_i  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return seed ^ (32'(i) * 32'h9E37_79B1);
    endfunction

    // 1-cycle single-port RAM; rdata carries junk on writes and idle cycles
    assign ram_rvalid = rv_q | force_rv;
    assign ram_rdata  = rd_q;

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= init_word(i);
            rv_q <= 1'b0;
            rd_q <= 32'h0;
        end else begin
            rv_q <= ram_req;
            rd_q <= 32'hDEAD_BEEF;
            if (ram_req) begin
                if (ram_we) begin
                    for (int k = 0; k < 4; k++)
                        if (ram_be[k]) mem[ram_addr[8:2]][8*k +: 8] <= ram_wdata[8*k +: 8];
                end else begin
                    rd_q <= mem[ram_addr[8:2]];
                end
            end
        end
    end

    task automatic set_idle;
        a_req = 0; a_we = 0; a_be = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_be = 0; b_addr = 0; b_wdata = 0;
    endtask

    // One clock of stimulus; checks every output against the model at the negedge.
    task automatic cycle(input logic ar, input logic aw, input logic [3:0] abe,
                         input logic [31:0] aad, input logic [31:0] awd,
                         input logic br, input logic bw, input logic [3:0] bbe,
                         input logic [31:0] bad, input logic [31:0] bwd);
        int          win;
        int          idx;
        logic        w_we;
        logic [3:0]  w_be;
        logic [31:0] w_addr, w_wd, off;
        logic        inr;
        logic [71:0] e_bus, o_bus;
        logic [33:0] e_ra, e_rb, o_ra, o_rb;
        a_req = ar; a_we = aw; a_be = abe; a_addr = aad; a_wdata = awd;
        b_req = br; b_we = bw; b_be = bbe; b_addr = bad; b_wdata = bwd;
        @(negedge clk);
        win = 0;
        if (ar && br)  win = m_prio_b ? 2 : 1;
        else if (ar)   win = 1;
        else if (br)   win = 2;
        w_we   = (win == 2) ? bw  : aw;
        w_be   = (win == 2) ? bbe : abe;
        w_addr = (win == 2) ? bad : aad;
        w_wd   = (win == 2) ? bwd : awd;
        off    = w_addr - BASE;
        inr    = (win != 0) && (off < 32'(WORDS * 4));
        idx    = int'(off >> 2);
        e_bus  = inr ? {(win == 1), (win == 2), 1'b1, w_we, w_be, off, w_wd}
                     : {(win == 1), (win == 2), 70'b0};
        o_bus  = {a_gnt, b_gnt, ram_req, ram_we, ram_be, ram_addr, ram_wdata};
        e_ra   = (m_pend && !m_owner_b) ? {1'b1, m_err, m_rdata} : 34'b0;
        e_rb   = (m_pend &&  m_owner_b) ? {1'b1, m_err, m_rdata} : 34'b0;
        o_ra   = {a_rvalid, a_err, a_rdata};
        o_rb   = {b_rvalid, b_err, b_rdata};
        obs_gnt     = {a_gnt, b_gnt};
        obs_b_rdata = b_rdata;
        checks++;
        if (o_bus !== e_bus) begin
            errors++;
            $display("FAIL grant_bus at %0t: got %h expected %h", $time, o_bus, e_bus);
        end
        checks++;
        if (o_ra !== e_ra) begin
            errors++;
            $display("FAIL resp_a at %0t: got %h expected %h", $time, o_ra, e_ra);
        end
        checks++;
        if (o_rb !== e_rb) begin
            errors++;
            $display("FAIL resp_b at %0t: got %h expected %h", $time, o_rb, e_rb);
        end
        // expected response for next cycle, then commit any write
        m_pend = (win != 0);
        if (win != 0) begin
            m_owner_b = (win == 2);
            m_err     = !inr;
            m_rdata   = (!inr || w_we) ? 32'h0 : ref_mem[idx];
            if (inr && w_we)
                for (int k = 0; k < 4; k++)
                    if (w_be[k]) ref_mem[idx][8*k +: 8] = w_wd[8*k +: 8];
`ifdef RAM_ARB_ROUND_ROBIN_EN
            m_prio_b = (win == 1);
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle;
        cycle(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset;
        logic [139:0] o_all;
        repeat (2) @(posedge clk);
        @(negedge clk);
        o_all = {a_gnt, b_gnt, ram_req, ram_we, ram_be, ram_addr, ram_wdata,
                 a_rvalid, a_err, a_rdata, b_rvalid, b_err, b_rdata};
        checks++;
        if (o_all !== 140'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", o_all);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        ram_load = 1'b0;
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_contention;
        logic [1:0] exp_g;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 4'hF, BASE + 32'h40, 32'h0, 1, 0, 4'hF, BASE + 32'h44, 32'h0);
`ifdef RAM_ARB_ROUND_ROBIN_EN
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            checks++;
            if (obs_gnt !== exp_g) begin
                errors++;
                $display("FAIL contention_%0d: gnt {a,b} got %b expected %b", i, obs_gnt, exp_g);
            end
        end
        idle_cycle();
    endtask

    task automatic test_directed;
        logic [31:0] w1;
        logic [31:0] exp_rd;
        // in-range read by A
        cycle(1, 0, 4'hF, 32'h0010_0008, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        idle_cycle();
        // partial write by B, then read back
        w1 = init_word(1);
        exp_rd = {w1[31:16], 16'hCCDD};
        cycle(0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 4'b0011, 32'h0010_0004, 32'hAABB_CCDD);
        cycle(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'hF, 32'h0010_0004, 32'h0);
        idle_cycle();
        checks++;
        if (obs_b_rdata !== exp_rd) begin
            errors++;
            $display("FAIL partial_write_readback: got %h expected %h", obs_b_rdata, exp_rd);
        end
        // out-of-range reads: below base, just past the end, and the last valid word
        cycle(1, 0, 4'hF, 32'h0000_0000, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        cycle(1, 0, 4'hF, BASE + 32'h200, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        cycle(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'hF, BASE + 32'h1FC, 32'h0);
        cycle(0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 4'hF, BASE - 32'h4, 32'h1234_5678);
        idle_cycle();
    endtask

    task automatic test_idle_rvalid;
        force_rv = 1'b1;
        repeat (3) idle_cycle();
        force_rv = 1'b0;
        idle_cycle();
    endtask

    function automatic logic [31:0] rand_addr;
        if ($urandom_range(0, 7) == 0) return $urandom;
        return BASE + (32'($urandom_range(0, WORDS - 1)) << 2);
    endfunction

    task automatic test_random;
        logic        ar, aw, br, bw;
        logic [3:0]  abe, bbe;
        logic [31:0] aad, awd, bad, bwd;
        ar = 0; aw = 0; abe = 0; aad = 0; awd = 0;
        br = 0; bw = 0; bbe = 0; bad = 0; bwd = 0;
        obs_gnt = 2'b00;
        for (int n = 0; n < 400; n++) begin
            // a host that lost arbitration keeps its request unchanged
            if (!(ar && !obs_gnt[1])) begin
                ar = ($urandom_range(0, 2) != 0); aw = $urandom_range(0, 1) == 1;
                abe = 4'($urandom); aad = rand_addr(); awd = $urandom;
            end
            if (!(br && !obs_gnt[0])) begin
                br = ($urandom_range(0, 2) != 0); bw = $urandom_range(0, 1) == 1;
                bbe = 4'($urandom); bad = rand_addr(); bwd = $urandom;
            end
            force_rv = ($urandom_range(0, 3) == 0);
            cycle(ar, aw, abe, aad, awd, br, bw, bbe, bad, bwd);
        end
        force_rv = 1'b0;
        idle_cycle();
    endtask

    task automatic test_reset_mid;
        logic [1:0] o_rv;
        cycle(1, 0, 4'hF, BASE + 32'h10, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_idle();
        rst_n    = 1'b0;
        m_pend   = 1'b0;
        m_prio_b = 1'b1;
        @(negedge clk);
        o_rv = {a_rvalid, b_rvalid};
        checks++;
        if (o_rv !== 2'b00) begin
            errors++;
            $display("FAIL reset_drop: rvalid {a,b} got %b expected 00", o_rv);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycle();
        idle_cycle();
        cycle(1, 0, 4'hF, BASE + 32'h20, 32'h0, 1, 0, 4'hF, BASE + 32'h24, 32'h0);
        checks++;
        if (obs_gnt !== 2'b01) begin
            errors++;
            $display("FAIL reset_prio: gnt {a,b} got %b expected 01", obs_gnt);
        end
        idle_cycle();
    endtask

    initial begin
        seed     = $urandom;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        rst_n    = 1'b0;
        ram_load = 1'b1;
        force_rv = 1'b0;
        m_pend   = 1'b0;
        m_owner_b = 1'b0;
        m_err    = 1'b0;
        m_rdata  = 32'h0;
        m_prio_b = 1'b1;
        obs_gnt  = 2'b00;
        obs_b_rdata = 32'h0;
        set_idle();
        test_reset();
        test_contention();
        test_directed();
        test_idle_rvalid();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
